// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that stores words in an external single-port synchronous RAM
// (registered read data, one-cycle latency) and presents them through an output register.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int DEPTH         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic [ADDRESS_WIDTH:0]   level
);

  localparam int CW = ADDRESS_WIDTH + 1;

  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            mem_count_q, mem_count_d;
  logic [CW-1:0]            level_q, level_d;
  logic                     rd_pend_q, rd_pend_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic                     rd_issue, accept, pop;

  // Wrap at DEPTH-1 rather than relying on natural overflow, so DEPTH need not be a power of two.
  function automatic logic [ADDRESS_WIDTH-1:0] next_ptr(input logic [ADDRESS_WIDTH-1:0] p);
    return (p == ADDRESS_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop      = out_valid_q && out_ready;
  assign rd_issue = (mem_count_q != '0) && !rd_pend_q && (!out_valid_q || out_ready);
  assign in_ready = (mem_count_q < CW'(DEPTH)) && !rd_issue && !rst;
  assign accept   = in_valid && in_ready;

  // The RAM port is shared: a write only happens when no read is being issued.
  assign ram_we   = accept;
  assign ram_addr = accept ? wr_ptr_q : rd_ptr_q;
  assign ram_din  = in_data;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    rd_pend_d   = rd_pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (accept) begin
      wr_ptr_d    = next_ptr(wr_ptr_q);
      mem_count_d = mem_count_q + 1'b1;
    end else if (rd_issue) begin
      rd_ptr_d    = next_ptr(rd_ptr_q);
      mem_count_d = mem_count_q - 1'b1;
    end

    // A capture reloads the output register and wins over a pop on the same edge.
    if (rd_pend_q) begin
      out_data_d  = ram_dout;
      out_valid_d = 1'b1;
      rd_pend_d   = 1'b0;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
    if (rd_issue) rd_pend_d = 1'b1;

    level_d = mem_count_d + CW'(rd_pend_d) + CW'(out_valid_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      level_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      level_q     <= level_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: behavioural RAM, queue-based FIFO model,
// directed scenarios plus randomized traffic.
module tb_ram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [AW:0]   level;

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .level(level)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with registered read data.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int          total = 0;
  int          bad   = 0;
  logic [DW-1:0] q [$];
  int          wptr_m = 0;
  int          n_acc  = 0;
  logic        last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: judge handshakes before the edge, check the held count after it.
  task automatic tick();
    logic          acc, pp;
    logic [DW-1:0] exp_w;
    @(negedge clk);
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    check("ram_we", ram_we, acc);
    if (acc) begin
      check("wr_addr", ram_addr, wptr_m);
      check("wr_din", ram_din, in_data);
    end
    if (pp) begin
      check("pop_nonempty", q.size() > 0, 1);
      if (q.size() > 0) begin
        exp_w = q.pop_front();
        check("pop_data", out_data, exp_w);
      end
    end
    if (acc) begin
      q.push_back(in_data);
      wptr_m = (wptr_m + 1) % DEPTH;
      n_acc++;
    end
    @(posedge clk);
    #1;
    check("level", level, q.size());
    last_acc = acc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_we", ram_we, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    wptr_m = 0;
    check("rst_level", level, 0);
    check("rst_out_valid", out_valid, 0);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && q.size() > 0; c++) tick();
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] nxt;
    int            sent;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    do_reset();

    // Single word latency: accept at E, visible after E+2.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    check("lat_accept", last_acc, 1);
    in_valid = 1'b0;
    tick();
    check("lat_e1_valid", out_valid, 0);
    tick();
    check("lat_e2_valid", out_valid, 1);
    check("lat_e2_data", out_data, 8'hA5);
    check("lat_level", level, 1);
    drain();

    // Fill to capacity with the consumer stalled, then drain in order.
    do_reset();
    n_acc = 0;
    nxt = 8'h00;
    for (int c = 0; c < 40; c++) begin
      in_valid = (nxt <= 8'h12);
      in_data  = nxt;
      tick();
      if (last_acc) nxt++;
    end
    in_valid = 1'b1;
    #1;
    check("fill_count", n_acc, 17);
    check("fill_level", level, 17);
    check("fill_in_ready", in_ready, 0);
    check("fill_out_data", out_data, 8'h00);
    drain();

    // Idle with nothing stored: no spurious output.
    for (int c = 0; c < 4; c++) tick();
    check("idle_valid", out_valid, 0);

    // Both sides always willing, 100 random words.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sent = 0;
    in_data = DW'($urandom);
    for (int c = 0; c < 1000 && sent < 100; c++) begin
      tick();
      if (last_acc) begin
        sent++;
        in_data = DW'($urandom);
      end
      in_valid = (sent < 100);
    end
    check("stream_sent", sent, 100);
    drain();

    // Random valid/ready patterns.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      if (c >= 300) out_ready = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      tick();
    end
    drain();

    // Reset in the middle of a stream discards everything.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(8'h50 + i);
      tick();
    end
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    check("post_rst_accept", last_acc, 1);
    in_valid = 1'b0;
    for (int c = 0; c < 10 && !out_valid; c++) tick();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 8'h3C);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
